uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 25000000, i_Clk frequency in Hz.
REQ-003 SHALL derive local CLKS_PER_BIT = CLK_HZ/BAUD_RATE (integer division; 217 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (108 at defaults).
REQ-004 SHALL have port i_Clk, input, 1, the single system clock; all logic rising-edge.
REQ-005 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_rx_serial, input, 1, asynchronous serial line, idle high; it is the o_tx_serial of uart_tx.
REQ-007 SHALL have port o_data, output, 8, last correctly received byte.
REQ-008 SHALL have port o_rx_done, output, 1, one-cycle pulse when o_data is updated.
REQ-009 SHALL have port o_frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass i_rx_serial through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s only.
REQ-012 SHALL frame as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 SHALL implement states IDLE, START, DATA, STOP with a bit-period counter (width >= clog2(CLKS_PER_BIT)) and a 3-bit bit index.
REQ-014 IDLE: on rx_s == 0 SHALL clear the counter and move to START; otherwise remain.
REQ-015 START: when counter == HALF_BIT-1, SHALL go to DATA with counter and bit index cleared if rx_s == 0, else SHALL return to IDLE (glitch reject, no output pulse); otherwise increment counter.
REQ-016 DATA: when counter == CLKS_PER_BIT-1, SHALL shift rx_s into shift-register position bit index, clear counter, and after index 7 go to STOP; otherwise increment counter.
REQ-017 STOP: when counter == CLKS_PER_BIT-1, SHALL, if rx_s == 1, load o_data from the shift register and pulse o_rx_done; if rx_s == 0, pulse o_frame_err and leave o_data unchanged; in both cases go to IDLE on the same edge.
REQ-018 Sampling therefore lands at the centre of every bit; return to IDLE at mid-stop-bit SHALL allow a back-to-back next start bit to be caught.
REQ-019 o_rx_done and o_frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one i_Clk cycle per frame.
REQ-020 o_data SHALL hold its value between frames and during reception (shift register is internal).
REQ-021 Line held low (break) SHALL produce o_frame_err once, then the FSM SHALL stay in IDLE-to-START cycling only after rx_s returns high; a new START requires rx_s == 0 seen in IDLE after a high.
REQ-022 rx_done latency: o_rx_done SHALL rise within 2 + HALF_BIT + 9*CLKS_PER_BIT + 2 i_Clk cycles of the falling start edge on i_rx_serial.

Reset
REQ-023 On i_reset high, asynchronously: state IDLE, counter 0, bit index 0, shift register 0x00, o_data 0x00, o_rx_done 0, o_frame_err 0, o_busy 0.
REQ-024 Synchronizer flops SHALL reset to 1 so reset release on an idle line causes no false start.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse on o_rx_done or o_frame_err; reception resumes at the next falling edge after release.

Verification
REQ-026 Drive 0x92 at 115200 baud via uart_tx model (25 MHz clock) -> one o_rx_done pulse, o_data = 0x92, o_frame_err stays 0, o_busy low afterwards.
REQ-027 Frames 0x59 then 0x00 back-to-back, no idle gap -> two o_rx_done pulses, o_data 0x59 then 0x00.
REQ-028 Low glitch of 50 clocks on idle line -> FSM returns to IDLE, no o_rx_done, no o_frame_err, o_data unchanged.
REQ-029 Frame 0xA5 with stop bit forced 0 -> one o_frame_err pulse, no o_rx_done, o_data retains previous value.
REQ-030 Assert i_reset during data bit 4 of 0xFF, release before frame end -> no pulse, o_data = 0x00; next frame 0x3C received correctly.
REQ-031 Check all pulses are exactly one cycle wide and sample points within +-1 clock of bit centres.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchronizer, mid-bit sampling and frame-error detection
module uart_rx #(
    parameter int BAUD_RATE = 115200,
    parameter int CLK_HZ    = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_reset,
    input  logic       i_rx_serial,
    output logic [7:0] o_data,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             wait_q, wait_d;
    logic [1:0]       sync_q, sync_d;
    logic             rx_s;

    assign sync_d      = {sync_q[0], i_rx_serial};
    assign rx_s        = sync_q[1];
    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = state_q != IDLE;

    // Register file; the synchronizer resets to the idle-high line level so release never looks like a start bit
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            wait_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            wait_q  <= wait_d;
            sync_q  <= sync_d;
        end
    end

    // Next-state logic; wait_q blocks a restart after a low stop bit until the line has been seen high again
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (rx_s) begin
                    wait_d = 1'b0;
                end else if (!wait_q) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    state_d        = (idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    data_d  = rx_s ? shift_q : data_q;
                    done_d  = rx_s;
                    ferr_d  = !rx_s;
                    wait_d  = !rx_s;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
